// File: rtl/esd_pkg.sv
// Shared constants for the emergency shutdown chain: state encodings,
// timer width and the millisecond-to-cycle conversion.
package esd_pkg;

    localparam int TIMER_W = 32;

    localparam logic [2:0] S_SAFE  = 3'd0;
    localparam logic [2:0] S_CLOSE = 3'd1;
    localparam logic [2:0] S_BRAKE = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DECEL = 3'd4;
    localparam logic [2:0] S_OPEN  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    function automatic logic [TIMER_W-1:0] ms_to_cycles(input int unsigned clk_hz,
                                                        input int unsigned ms);
        return TIMER_W'((clk_hz / 1000) * ms);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// State dwell timer: counts while enabled, clears on state entry, and
// flags the last cycle of a limit-cycle dwell.
module seq_timer
    import esd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = en && (cnt_reg == (limit - 1'b1));

endmodule

// File: rtl/shutdown_sequencer.sv
// Turns the shutdown request level into timed contactor/brake/drive
// actuation with contactor feedback supervision and a latched fault.
module shutdown_sequencer
    import esd_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned STOP_DELAY_MS = 100,
    parameter int unsigned BRAKE_MS      = 20,
    parameter int unsigned FB_TIMEOUT_MS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shutdown_req,
    input  logic       fault_clr,
    input  logic       fb_closed,
    output logic       contactor_on,
    output logic       brake_release,
    output logic       drive_enable,
    output logic       seq_fault,
    output logic [2:0] state_o
);

    localparam logic [TIMER_W-1:0] N_STOP  = ms_to_cycles(CLK_HZ, STOP_DELAY_MS);
    localparam logic [TIMER_W-1:0] N_BRAKE = ms_to_cycles(CLK_HZ, BRAKE_MS);
    localparam logic [TIMER_W-1:0] N_FB    = ms_to_cycles(CLK_HZ, FB_TIMEOUT_MS);

    logic [2:0]         state_reg, state_next;
    logic               fb_meta_reg, fb_s_reg;
    logic               timer_en, timer_clr, timer_expired;
    logic [TIMER_W-1:0] timer_limit;
    logic               contactor_reg, brake_reg, drive_reg, fault_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_meta_reg <= 1'b0;
            fb_s_reg    <= 1'b0;
        end else begin
            fb_meta_reg <= fb_closed;
            fb_s_reg    <= fb_meta_reg;
        end
    end

    always_comb begin
        timer_en    = 1'b0;
        timer_limit = N_FB;
        case (state_reg)
            S_CLOSE: begin timer_en = 1'b1; timer_limit = N_FB;    end
            S_BRAKE: begin timer_en = 1'b1; timer_limit = N_BRAKE; end
            S_DECEL: begin timer_en = 1'b1; timer_limit = N_STOP;  end
            S_OPEN:  begin timer_en = 1'b1; timer_limit = N_FB;    end
            default: begin timer_en = 1'b0; timer_limit = N_FB;    end
        endcase
    end

    // Any state change restarts the dwell count for the state being entered.
    assign timer_clr = (state_next != state_reg);

    seq_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_SAFE: begin
                if (fb_s_reg)           state_next = S_FAULT;
                else if (!shutdown_req) state_next = S_CLOSE;
            end
            S_CLOSE: begin
                if (timer_expired && !fb_s_reg) state_next = S_FAULT;
                else if (shutdown_req)          state_next = S_OPEN;
                else if (fb_s_reg)              state_next = S_BRAKE;
            end
            S_BRAKE: begin
                if (!fb_s_reg)          state_next = S_FAULT;
                else if (shutdown_req)  state_next = S_OPEN;
                else if (timer_expired) state_next = S_RUN;
            end
            S_RUN: begin
                if (!fb_s_reg)         state_next = S_FAULT;
                else if (shutdown_req) state_next = S_DECEL;
            end
            S_DECEL: begin
                if (!fb_s_reg)          state_next = S_FAULT;
                else if (timer_expired) state_next = S_OPEN;
            end
            S_OPEN: begin
                // Feedback release wins over a timeout landing on the same cycle.
                if (!fb_s_reg)          state_next = S_SAFE;
                else if (timer_expired) state_next = S_FAULT;
            end
            S_FAULT: begin
                if (fault_clr && shutdown_req && !fb_s_reg) state_next = S_SAFE;
            end
            default: state_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_SAFE;
            contactor_reg <= 1'b0;
            brake_reg     <= 1'b0;
            drive_reg     <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_next)
                S_SAFE:  {contactor_reg, brake_reg, drive_reg, fault_reg} <= 4'b0000;
                S_CLOSE: {contactor_reg, brake_reg, drive_reg, fault_reg} <= 4'b1000;
                S_BRAKE: {contactor_reg, brake_reg, drive_reg, fault_reg} <= 4'b1100;
                S_RUN:   {contactor_reg, brake_reg, drive_reg, fault_reg} <= 4'b1110;
                S_DECEL: {contactor_reg, brake_reg, drive_reg, fault_reg} <= 4'b1100;
                S_OPEN:  {contactor_reg, brake_reg, drive_reg, fault_reg} <= 4'b0000;
                default: {contactor_reg, brake_reg, drive_reg, fault_reg} <= 4'b0001;
            endcase
        end
    end

    assign contactor_on  = contactor_reg;
    assign brake_release = brake_reg;
    assign drive_enable  = drive_reg;
    assign seq_fault     = fault_reg;
    assign state_o       = state_reg;

    drive_needs_brake_and_power: assert property (@(posedge clk) disable iff (!rst_n)
        drive_enable |-> (brake_release && contactor_on));

endmodule

// File: tb/tb_shutdown_sequencer.sv
// Directed bench for shutdown_sequencer at 10 cycles/ms: vector table for
// start/stop/timeout, hand sequences for welded contact, drop, abort, reset.
module tb_shutdown_sequencer;

    logic       clk;
    logic       rst_n;
    logic       shutdown_req;
    logic       fault_clr;
    logic       fb_closed;
    logic       contactor_on;
    logic       brake_release;
    logic       drive_enable;
    logic       seq_fault;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;
    logic watch_decel = 1'b0;
    logic saw_decel   = 1'b0;

    shutdown_sequencer #(
        .CLK_HZ        (10000),
        .STOP_DELAY_MS (3),
        .BRAKE_MS      (1),
        .FB_TIMEOUT_MS (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .shutdown_req  (shutdown_req),
        .fault_clr     (fault_clr),
        .fb_closed     (fb_closed),
        .contactor_on  (contactor_on),
        .brake_release (brake_release),
        .drive_enable  (drive_enable),
        .seq_fault     (seq_fault),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch_decel && state_o == 3'd4) saw_decel = 1'b1;
    end

    typedef struct {
        logic       rst_n;
        logic       req;
        logic       clr;
        logic       fb;
        int         n;
        logic [2:0] st;
        logic [3:0] cbdf;
        string      name;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [2:0] st, input logic [3:0] cbdf);
        logic [6:0] act;
        logic [6:0] exp;
        act = {state_o, contactor_on, brake_release, drive_enable, seq_fault};
        exp = {st, cbdf};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%0d c/b/d/f=%b, want state=%0d c/b/d/f=%b",
                     name, act[6:4], act[3:0], st, cbdf);
        end else begin
            $display("ok   %s: state=%0d c/b/d/f=%b", name, st, cbdf);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int k;
        k = 0;
        while (state_o !== st && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (state_o !== st) begin
            n_err++;
            $display("FAIL %s: state=%0d after %0d cycles, want state=%0d", name, state_o, k, st);
        end else begin
            $display("ok   %s: reached state=%0d after %0d cycles", name, st, k);
        end
    endtask

    // Fault exit needs feedback open, shutdown held and a clear pulse.
    task automatic clear_fault(input string name);
        fb_closed = 1'b0;
        tick(3);
        shutdown_req = 1'b1;
        fault_clr    = 1'b1;
        tick(1);
        fault_clr    = 1'b0;
        check(name, 3'd0, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, req, clr, fb, cycles to wait, expected state, c/b/d/f
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2,  3'd0, 4'b0000, "reset_state"};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  3'd1, 4'b1000, "close_entry"};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4,  3'd1, 4'b1000, "close_wait_fb"};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  3'd1, 4'b1000, "close_wait_fb2"};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2,  3'd1, 4'b1000, "fb_in_sync"};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  3'd2, 4'b1100, "brake_release"};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 9,  3'd2, 4'b1100, "brake_last_cycle"};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  3'd3, 4'b1110, "run_drive_on"};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd4, 4'b1100, "decel_drive_off"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 29, 3'd4, 4'b1100, "decel_last_cycle"};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  3'd5, 4'b0000, "open_after_stop"};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2,  3'd5, 4'b0000, "open_fb_in_sync"};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  3'd0, 4'b0000, "safe_after_stop"};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  3'd1, 4'b1000, "close_no_fb"};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 19, 3'd1, 4'b1000, "close_timeout_edge"};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  3'd6, 4'b0001, "close_timeout_fault"};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1,  3'd6, 4'b0001, "clr_without_req"};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  3'd6, 4'b0001, "req_without_clr"};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  3'd0, 4'b0000, "clr_with_req"};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 2,  3'd0, 4'b0000, "safe_hold_req"};

        rst_n = 1'b0; shutdown_req = 1'b0; fault_clr = 1'b0; fb_closed = 1'b0;

        for (int i = 0; i < 20; i++) begin
            rst_n        = vecs[i].rst_n;
            shutdown_req = vecs[i].req;
            fault_clr    = vecs[i].clr;
            fb_closed    = vecs[i].fb;
            tick(vecs[i].n);
            check(vecs[i].name, vecs[i].st, vecs[i].cbdf);
        end
        fault_clr = 1'b0;

        // Welded contact seen while safe.
        fb_closed = 1'b1;
        tick(2);
        check("safe_fb_not_yet", 3'd0, 4'b0000);
        tick(1);
        check("safe_welded_fault", 3'd6, 4'b0001);
        clear_fault("clear_after_safe_weld");

        // Abort from brake straight to open, then welded contact in open.
        watch_decel  = 1'b1;
        shutdown_req = 1'b0;
        fb_closed    = 1'b1;
        wait_state(3'd2, 10, "reach_brake");
        shutdown_req = 1'b1;
        tick(1);
        check("abort_brake_to_open", 3'd5, 4'b0000);
        tick(19);
        check("open_welded_last", 3'd5, 4'b0000);
        tick(1);
        check("open_welded_fault", 3'd6, 4'b0001);
        watch_decel = 1'b0;
        n_cmp++;
        if (saw_decel !== 1'b0) begin
            n_err++;
            $display("FAIL abort_skips_decel: decel visited=%b, want 0", saw_decel);
        end else begin
            $display("ok   abort_skips_decel: decel visited=0");
        end
        clear_fault("clear_after_open_weld");

        // Contactor drops out while running.
        shutdown_req = 1'b0;
        fb_closed    = 1'b1;
        wait_state(3'd3, 40, "reach_run_for_drop");
        fb_closed = 1'b0;
        tick(2);
        check("run_drop_not_yet", 3'd3, 4'b1110);
        tick(1);
        check("run_drop_fault", 3'd6, 4'b0001);
        clear_fault("clear_after_drop");

        // Asynchronous reset in the middle of deceleration.
        shutdown_req = 1'b0;
        fb_closed    = 1'b1;
        wait_state(3'd3, 40, "reach_run_for_reset");
        shutdown_req = 1'b1;
        tick(5);
        check("decel_before_reset", 3'd4, 4'b1100);
        #2;
        rst_n     = 1'b0;
        fb_closed = 1'b0;
        #1;
        check("async_reset_mid_decel", 3'd0, 4'b0000);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("safe_after_reset", 3'd0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shutdown_sequencer.md
Name: shutdown_sequencer

Overview:
- Downstream stage of the emergency shutdown controller.
- Consumes the registered shutdown level and turns it into timed physical actuation of three outputs: line contactor, mechanical brake release, and drive enable.
- Applies an SS1-style controlled stop (decelerate, then cut power), monitors the contactor's mirror-contact feedback, and latches a sequence fault on feedback disagreement or timeout.

Parameters:
CLK_HZ, 50000000, clock frequency in Hz
STOP_DELAY_MS, 100, decel time with drive disabled before brake engages and contactor opens
BRAKE_MS, 20, brake-release settle time before drive enable
FB_TIMEOUT_MS, 50, max time for contactor feedback to follow the command

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
shutdown_req  in  1  1 = stop requested (level, already synchronous to clk)
fault_clr  in  1  1-cycle clear pulse (ack pulse)
fb_closed  in  1  contactor mirror contact, 1 = closed (asynchronous, noisy-free)
contactor_on  out  1  1 = energise line contactor
brake_release  out  1  1 = release mechanical brake
drive_enable  out  1  1 = motor drive enabled
seq_fault  out  1  latched sequence fault
state_o  out  3  current state encoding, for debug/LED

Behaviour:
- Reset (async): state=S_SAFE; all outputs 0; timer=0; fb synchroniser flops=0.
- fb_closed passes through a 2-FF synchroniser to give fb_s; all decisions use fb_s (2-cycle latency).
- Cycle counts: N_x = (CLK_HZ/1000)*x_MS. Timer is 32-bit, cleared on every state entry, increments each cycle in a timed state.
  - A timed expiry fires when timer==N-1, so the state occupies exactly N cycles.
- Outputs are registered, decoded from the next state, and change on the same edge as the state register.
- States (encoding) and output drive, contactor/brake/drive/fault:
  - S_SAFE(0): 0/0/0/0
  - S_CLOSE(1): 1/0/0/0
  - S_BRAKE(2): 1/1/0/0
  - S_RUN(3): 1/1/1/0
  - S_DECEL(4): 1/1/0/0
  - S_OPEN(5): 0/0/0/0
  - S_FAULT(6): 0/0/0/1
- Transitions:
  - S_SAFE: fb_s=1 -> S_FAULT (welded contact), else shutdown_req=0 -> S_CLOSE.
  - S_CLOSE: shutdown_req=1 -> S_OPEN; fb_s=1 -> S_BRAKE; timer==N_FB-1 with fb_s=0 -> S_FAULT.
  - S_BRAKE: shutdown_req=1 -> S_OPEN; fb_s=0 -> S_FAULT; timer==N_BRAKE-1 -> S_RUN.
  - S_RUN: fb_s=0 -> S_FAULT (contactor dropped); shutdown_req=1 -> S_DECEL.
  - S_DECEL: fb_s=0 -> S_FAULT; timer==N_STOP-1 -> S_OPEN. shutdown_req deassertion is ignored here; the stop always completes.
  - S_OPEN: fb_s=0 -> S_SAFE; timer==N_FB-1 with fb_s=1 -> S_FAULT.
  - S_FAULT: fault_clr=1 AND shutdown_req=1 AND fb_s=0 -> S_SAFE; otherwise stays. fault_clr is ignored in all other states.
- Priority within a state: fault conditions > shutdown_req > timer expiry.
  - Exception: feedback success arriving on the same cycle as timeout expiry counts as success.
- shutdown_req rising during S_CLOSE/S_BRAKE skips S_DECEL, because the drive was never enabled.
- Unused encoding 7 -> S_FAULT on the next edge.
- Invariant, checked by assertion: drive_enable=1 implies brake_release=1 and contactor_on=1.

Decomposition:
- Package esd_pkg holds:
  - the state localparams S_SAFE..S_FAULT (3-bit);
  - function ms_to_cycles(clk_hz, ms);
  - the TIMER_W=32 constant.
- Sub-module seq_timer:
  - ports: clk, rst_n, clr, en, limit[31:0], expired;
  - expired = (cnt==limit-1) & en;
  - cnt clears on clr, holds when !en.
- Synchroniser stays inline (two flops).

Test Plan (CLK_HZ=10000 giving 10 cyc/ms; STOP_DELAY_MS=3 -> 30 cyc, BRAKE_MS=1 -> 10 cyc, FB_TIMEOUT_MS=2 -> 20 cyc):
1. Normal start: reset release with shutdown_req=0, fb_closed driven to 1 five cycles after contactor_on rises -> brake_release rises 2 sync cycles after fb, drive_enable exactly 10 cycles later, state_o=3.
2. Controlled stop: from S_RUN assert shutdown_req -> drive_enable=0 next edge, brake/contactor drop exactly 30 cycles later, fb->0 returns state_o=0 with seq_fault=0.
3. Close timeout: from S_SAFE with fb_closed held 0 -> seq_fault=1 and all drives 0 exactly 20 cycles after S_CLOSE entry. fault_clr with shutdown_req=0 -> stays S_FAULT; fault_clr with shutdown_req=1 -> S_SAFE.
4. Welded contact: S_OPEN with fb_closed stuck 1 -> S_FAULT after 20 cycles. Also fb_closed=1 in S_SAFE -> S_FAULT within 3 cycles.
5. Contactor drop in run: S_RUN, fb_closed->0 -> all outputs 0 and seq_fault=1 within 3 cycles.
6. Abort and reset: shutdown_req=1 during S_BRAKE -> S_OPEN directly, S_DECEL never visited. rst_n pulsed low mid-S_DECEL -> all outputs 0 asynchronously, state_o=0.
